// File: rtl/pad_ctrl.sv
// Pad-control and GPIO register block: input synchronisers, per-pad control registers,
// sticky edge flags with interrupt. Optional macro GPIO_FALLING_EDGE_EN adds EDGE_POL at 0x8A.
module pad_ctrl #(
  parameter int NUM_INPUT = 12,
  parameter int NUM_BIDIR = 42
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_INPUT-1:0] input_in,
  output logic [NUM_INPUT-1:0] input_pu,
  output logic [NUM_INPUT-1:0] input_pd,
  input  logic [NUM_BIDIR-1:0] bidir_in,
  output logic [NUM_BIDIR-1:0] bidir_out,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  input  logic                 reg_valid,
  output logic                 reg_ready,
  input  logic                 reg_we,
  input  logic [7:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 reg_rvalid,
  output logic                 irq
);

  logic [6:0]           bidir_cfg [NUM_BIDIR];
  logic [1:0]           input_cfg [NUM_INPUT];
  logic [NUM_INPUT-1:0] in_s1, in_s2, in_s3;
  logic [NUM_BIDIR-1:0] bd_s1, bd_s2;
  logic [NUM_INPUT-1:0] edge_flag, edge_mask, edge_set, w1c;
  logic [63:0]          bd_wide;
  logic [31:0]          rd_mux;
  logic                 ready_q, xfer, wr, rd;
  logic                 unused_wdata;

  assign reg_ready    = ready_q;
  assign xfer         = reg_valid & ready_q;
  assign wr           = xfer & reg_we;
  assign rd           = xfer & ~reg_we;
  assign bd_wide      = 64'(bd_s2);
  assign w1c          = (wr && reg_addr == 8'h88) ? reg_wdata[NUM_INPUT-1:0] : '0;
  assign unused_wdata = ^reg_wdata;

`ifdef GPIO_FALLING_EDGE_EN
  logic [NUM_INPUT-1:0] edge_pol;
  assign edge_set = (in_s2 & ~in_s3 & ~edge_pol) | (~in_s2 & in_s3 & edge_pol);
`else
  assign edge_set = in_s2 & ~in_s3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      in_s1   <= '0;
      in_s2   <= '0;
      in_s3   <= '0;
      bd_s1   <= '0;
      bd_s2   <= '0;
    end else begin
      ready_q <= 1'b1;
      in_s1   <= input_in;
      in_s2   <= in_s1;
      in_s3   <= in_s2;
      bd_s1   <= bidir_in;
      bd_s2   <= bd_s1;
    end
  end

  // Bidir reset state keeps input buffers enabled so pads are readable straight away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BIDIR; i++) bidir_cfg[i] <= 7'h10;
      for (int j = 0; j < NUM_INPUT; j++) input_cfg[j] <= 2'b00;
    end else if (wr) begin
      for (int i = 0; i < NUM_BIDIR; i++)
        if (reg_addr == 8'(i)) bidir_cfg[i] <= reg_wdata[6:0];
      for (int j = 0; j < NUM_INPUT; j++)
        if (reg_addr == 8'(64 + j)) input_cfg[j] <= reg_wdata[1:0];
    end
  end

  // A new edge beats a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_flag <= '0;
      edge_mask <= '0;
      irq       <= 1'b0;
    end else begin
      edge_flag <= (edge_flag & ~w1c) | edge_set;
      if (wr && reg_addr == 8'h89) edge_mask <= reg_wdata[NUM_INPUT-1:0];
      irq <= |(edge_flag & edge_mask);
    end
  end

`ifdef GPIO_FALLING_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       edge_pol <= '0;
    else if (wr && reg_addr == 8'h8A) edge_pol <= reg_wdata[NUM_INPUT-1:0];
  end
`endif

  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < NUM_BIDIR; i++)
      if (reg_addr == 8'(i)) rd_mux = {25'h0, bidir_cfg[i]};
    for (int j = 0; j < NUM_INPUT; j++)
      if (reg_addr == 8'(64 + j)) rd_mux = {30'h0, input_cfg[j]};
    case (reg_addr)
      8'h80:   rd_mux = bd_wide[31:0];
      8'h81:   rd_mux = bd_wide[63:32];
      8'h84:   rd_mux = 32'(in_s2);
      8'h88:   rd_mux = 32'(edge_flag);
      8'h89:   rd_mux = 32'(edge_mask);
`ifdef GPIO_FALLING_EDGE_EN
      8'h8A:   rd_mux = 32'(edge_pol);
`endif
      default: ;
    endcase
  end

  // Read data only moves on an accepted read, so it holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rdata  <= 32'h0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= rd;
      if (rd) reg_rdata <= rd_mux;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BIDIR; i++) begin
      bidir_out[i] = bidir_cfg[i][0];
      bidir_oe[i]  = bidir_cfg[i][1];
      bidir_cs[i]  = bidir_cfg[i][2];
      bidir_sl[i]  = bidir_cfg[i][3];
      bidir_ie[i]  = bidir_cfg[i][4];
      bidir_pu[i]  = bidir_cfg[i][5];
      bidir_pd[i]  = bidir_cfg[i][6];
    end
    for (int j = 0; j < NUM_INPUT; j++) begin
      input_pu[j] = input_cfg[j][0];
      input_pd[j] = input_cfg[j][1];
    end
  end

endmodule
